// File: rtl/bp_be_fe_queue_buffer_pkg.sv
// Shared types for the frontend-to-backend queue buffer.
// Defines the fe_queue message layout, its width and the default depth.
// Pure declarations: no logic, no latency, no flow control.
package bp_be_fe_queue_buffer_pkg;

  localparam int vaddr_width_lp       = 39;
  localparam int instr_width_lp       = 32;
  localparam int fe_queue_fifo_els_p  = 8;

  typedef enum logic [1:0] {
    e_msg_fetch       = 2'd0,
    e_msg_itlb_miss   = 2'd1,
    e_msg_fault       = 2'd2,
    e_msg_icache_miss = 2'd3
  } bp_fe_msg_type_e;

  typedef struct packed {
    bp_fe_msg_type_e             msg_type;
    logic [vaddr_width_lp-1:0]   pc;
    logic [instr_width_lp-1:0]   instr;
    logic                        partial_v;
  } bp_fe_queue_s;

  localparam int fe_queue_width_lp = $bits(bp_fe_queue_s);

endpackage

// File: rtl/bp_be_fe_queue_buffer_ptr_ctrl.sv
// Write / speculative-read / commit pointers with full, empty and replay rules.
// Latency: pointer updates take effect the cycle after the qualifying inputs.
// Backpressure: enq_ready_o = ~full & ~reset_i, from registered pointers only.
// Ports: clk_i/reset_i; enq_v_i, issue_yumi_i, commit_i, roll_i, clr_i in;
//        enq_ready_o, issue_v_o, empty_o, count_o, w_en_o, widx_o, ridx_o out.
module bp_be_fe_queue_buffer_ptr_ctrl #(
  parameter  int els_p        = 8,
  localparam int lg_els_lp    = $clog2(els_p),
  localparam int ptr_width_lp = lg_els_lp + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enq_v_i,
  input  logic                    issue_yumi_i,
  input  logic                    commit_i,
  input  logic                    roll_i,
  input  logic                    clr_i,
  output logic                    enq_ready_o,
  output logic                    issue_v_o,
  output logic                    empty_o,
  output logic [ptr_width_lp-1:0] count_o,
  output logic                    w_en_o,
  output logic [lg_els_lp-1:0]    widx_o,
  output logic [lg_els_lp-1:0]    ridx_o
);

  logic [ptr_width_lp-1:0] r_wptr, r_rptr, r_cptr;
  logic [ptr_width_lp-1:0] w_wptr_n, w_rptr_n, w_cptr_n;
  logic                    w_full;
  logic                    w_enq;

  // Same index with opposite wrap bits means the store is completely full.
  assign w_full      = (r_wptr[lg_els_lp] != r_cptr[lg_els_lp])
                     && (r_wptr[lg_els_lp-1:0] == r_cptr[lg_els_lp-1:0]);
  assign enq_ready_o = ~w_full & ~reset_i;
  assign w_enq       = enq_v_i & enq_ready_o;
  // A flushed enqueue still handshakes, but its data never lands.
  assign w_en_o      = w_enq & ~clr_i;

  assign issue_v_o   = (r_rptr != r_wptr) & ~reset_i;
  assign empty_o     = (r_cptr == r_wptr);
  assign count_o     = r_wptr - r_cptr;
  assign widx_o      = r_wptr[lg_els_lp-1:0];
  assign ridx_o      = r_rptr[lg_els_lp-1:0];

  always_comb begin
    w_cptr_n = r_cptr + ptr_width_lp'(commit_i);
    w_rptr_n = r_rptr;
    w_wptr_n = r_wptr;
    if (clr_i) begin
      w_wptr_n = w_cptr_n;
      w_rptr_n = w_cptr_n;
    end else if (roll_i) begin
      // Replay restarts issue from the post-commit point; yumi is ignored.
      w_rptr_n = w_cptr_n;
      w_wptr_n = r_wptr + ptr_width_lp'(w_enq);
    end else begin
      w_rptr_n = r_rptr + ptr_width_lp'(issue_yumi_i);
      w_wptr_n = r_wptr + ptr_width_lp'(w_enq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cptr <= '0;
    end else begin
      r_wptr <= w_wptr_n;
      r_rptr <= w_rptr_n;
      r_cptr <= w_cptr_n;
    end
  end

`ifndef SYNTHESIS
  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
    issue_yumi_i |-> issue_v_o);
  a_commit_needs_read: assert property (@(posedge clk_i) disable iff (reset_i)
    commit_i |-> (r_cptr != r_rptr));
`endif

endmodule

// File: rtl/bp_be_fe_queue_buffer.sv
// Backend receiver buffering fe_queue messages for speculative issue with replay/flush.
// Latency: an entry written in cycle N appears on issue_pkt_o in cycle N+1 (no bypass).
// Backpressure: fe_queue_ready_o drops when full; commits free space one cycle later.
// Ports: clk_i/reset_i; fe_queue_i/_v_i/_ready_o enqueue; issue_pkt_o/_v_o/_yumi_i issue;
//        commit_i, roll_i, clr_i control; empty_o, count_o status.
module bp_be_fe_queue_buffer
  import bp_be_fe_queue_buffer_pkg::*;
#(
  parameter  int els_p     = fe_queue_fifo_els_p,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_o,
  output logic [fe_queue_width_lp-1:0] issue_pkt_o,
  output logic                         issue_v_o,
  input  logic                         issue_yumi_i,
  input  logic                         commit_i,
  input  logic                         roll_i,
  input  logic                         clr_i,
  output logic                         empty_o,
  output logic [lg_els_lp:0]           count_o
);

  if ((els_p < 2) || ((els_p & (els_p - 1)) != 0)) begin : g_bad_els
    $error("els_p must be a power of 2 and at least 2");
  end

  logic                 w_wen;
  logic [lg_els_lp-1:0] w_widx;
  logic [lg_els_lp-1:0] w_ridx;

  bp_be_fe_queue_buffer_ptr_ctrl #(.els_p(els_p)) u_ptr_ctrl (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .enq_v_i      (fe_queue_v_i),
    .issue_yumi_i (issue_yumi_i),
    .commit_i     (commit_i),
    .roll_i       (roll_i),
    .clr_i        (clr_i),
    .enq_ready_o  (fe_queue_ready_o),
    .issue_v_o    (issue_v_o),
    .empty_o      (empty_o),
    .count_o      (count_o),
    .w_en_o       (w_wen),
    .widx_o       (w_widx),
    .ridx_o       (w_ridx)
  );

  // 1r1w storage: synchronous write, asynchronous read. Contents are never
  // cleared; the pointers alone decide what is live.
  logic [fe_queue_width_lp-1:0] r_mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_wen) begin
      r_mem[w_widx] <= fe_queue_i;
    end
  end

  assign issue_pkt_o = r_mem[w_ridx];

`ifndef SYNTHESIS
  a_payload_known: assert property (@(posedge clk_i) disable iff (reset_i)
    fe_queue_v_i |-> !$isunknown(fe_queue_i));
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
module tb_bp_be_fe_queue_buffer;
  import bp_be_fe_queue_buffer_pkg::*;

  localparam int ELS = 8;
  localparam int W   = fe_queue_width_lp;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [W-1:0] fe_queue_i;
  logic         fe_queue_v_i;
  logic         fe_queue_ready_o;
  logic [W-1:0] issue_pkt_o;
  logic         issue_v_o;
  logic         issue_yumi_i;
  logic         commit_i;
  logic         roll_i;
  logic         clr_i;
  logic         empty_o;
  logic [3:0]   count_o;

  always #5 clk_i = ~clk_i;

  bp_be_fe_queue_buffer #(.els_p(ELS)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .issue_pkt_o      (issue_pkt_o),
    .issue_v_o        (issue_v_o),
    .issue_yumi_i     (issue_yumi_i),
    .commit_i         (commit_i),
    .roll_i           (roll_i),
    .clr_i            (clr_i),
    .empty_o          (empty_o),
    .count_o          (count_o)
  );

  int n_asserts = 0;
  int n_fails   = 0;

  // Scoreboard: entries between commit and write; mr = how many are issued.
  logic [W-1:0] mq[$];
  int           mr;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int k);
    bp_fe_queue_s m;
    m           = '0;
    m.msg_type  = bp_fe_msg_type_e'(k[1:0]);
    m.pc        = 39'h8000_0000 + 39'(4 * k);
    m.instr     = 32'h0000_0013 + 32'(k);
    m.partial_v = k[0];
    return m;
  endfunction

  task automatic idle_inputs();
    fe_queue_v_i = 1'b0;
    issue_yumi_i = 1'b0;
    commit_i     = 1'b0;
    roll_i       = 1'b0;
    clr_i        = 1'b0;
  endtask

  // One clock: check outputs vs scoreboard, advance scoreboard with the
  // inputs about to be sampled, then return inputs to idle.
  task automatic cycle(input bit auto_yumi);
    bit exp_rdy, acc;
    @(negedge clk_i);
    exp_rdy = (mq.size() < ELS);
    chk("ready",   fe_queue_ready_o, exp_rdy);
    chk("count",   count_o,          mq.size());
    chk("empty",   empty_o,          mq.size() == 0);
    chk("issue_v", issue_v_o,        mr < mq.size());
    if (mr < mq.size()) chk("issue_pkt", issue_pkt_o, mq[mr]);
    if (auto_yumi) issue_yumi_i = (mr < mq.size());
    acc = fe_queue_v_i && exp_rdy;
    if (commit_i) begin
      void'(mq.pop_front());
      mr--;
    end
    if (clr_i) begin
      mq.delete();
      mr = 0;
    end else if (roll_i) begin
      mr = 0;
      if (acc) mq.push_back(fe_queue_i);
    end else begin
      if (issue_yumi_i) mr++;
      if (acc) mq.push_back(fe_queue_i);
    end
    @(posedge clk_i);
    #1;
    idle_inputs();
  endtask

  task automatic enq(input int k, input bit auto_yumi);
    fe_queue_i   = mk(k);
    fe_queue_v_i = 1'b1;
    cycle(auto_yumi);
  endtask

  task automatic yumi_n(input int n);
    repeat (n) begin
      issue_yumi_i = 1'b1;
      cycle(1'b0);
    end
  endtask

  task automatic commit_n(input int n);
    repeat (n) begin
      commit_i = 1'b1;
      cycle(1'b0);
    end
  endtask

  task automatic do_reset(input int n);
    reset_i = 1'b1;
    idle_inputs();
    repeat (n) begin
      @(negedge clk_i);
      chk("rst_ready",   fe_queue_ready_o, 1'b0);
      chk("rst_issue_v", issue_v_o,        1'b0);
      @(posedge clk_i);
      #1;
    end
    reset_i = 1'b0;
    mq.delete();
    mr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    bp_fe_queue_s pkt;
    fe_queue_i = '0;
    idle_inputs();
    mr = 0;

    // Reset, then idle: empty and zero count.
    do_reset(2);
    cycle(1'b0);
    chk("post_rst_empty", empty_o, 1'b1);
    chk("post_rst_count", count_o, 4'd0);

    // Three enqueues with issue consuming as soon as valid.
    enq(0, 1'b1);
    enq(1, 1'b1);
    enq(2, 1'b1);
    cycle(1'b1);
    cycle(1'b1);
    chk("peak_count", count_o, 4'd3);
    chk("drained_v",  issue_v_o, 1'b0);
    commit_n(3);
    cycle(1'b0);

    // Fill to full, back off, free one slot, wrap into index 0.
    do_reset(1);
    for (int k = 0; k < ELS; k++) enq(k, 1'b0);
    enq(8, 1'b0);
    chk("full_ready", fe_queue_ready_o, 1'b0);
    chk("full_count", count_o, 4'd8);
    yumi_n(1);
    commit_n(1);
    cycle(1'b0);
    enq(8, 1'b0);
    chk("wrap_wptr", dut.u_ptr_ctrl.r_wptr, 4'b1001);
    chk("wrap_mem0", dut.r_mem[0], mk(8));
    cycle(1'b0);

    // Issue 4, commit 2, roll: replay resumes at the 3rd entry.
    do_reset(1);
    for (int k = 0; k < ELS; k++) enq(k, 1'b0);
    yumi_n(4);
    commit_n(2);
    roll_i = 1'b1;
    cycle(1'b0);
    pkt = issue_pkt_o;
    chk("roll_pc",    pkt.pc,  39'h8000_0008);
    chk("roll_count", count_o, 4'd6);
    cycle(1'b0);

    // Issue 5, commit 3, flush with a concurrent enqueue that gets dropped.
    do_reset(1);
    for (int k = 0; k < ELS; k++) enq(k, 1'b0);
    yumi_n(5);
    commit_n(3);
    clr_i = 1'b1;
    enq(100, 1'b0);
    chk("clr_empty",   empty_o,   1'b1);
    chk("clr_count",   count_o,   4'd0);
    chk("clr_issue_v", issue_v_o, 1'b0);
    enq(9, 1'b0);
    pkt = issue_pkt_o;
    chk("post_clr_v",  issue_v_o, 1'b1);
    chk("post_clr_pc", pkt.pc,    39'h8000_0024);
    cycle(1'b0);

    // Commit together with roll from rptr=5, cptr=2.
    do_reset(1);
    for (int k = 0; k < ELS; k++) enq(k, 1'b0);
    yumi_n(5);
    commit_n(2);
    commit_i = 1'b1;
    roll_i   = 1'b1;
    cycle(1'b0);
    chk("cr_rptr",  dut.u_ptr_ctrl.r_rptr, 4'd3);
    chk("cr_cptr",  dut.u_ptr_ctrl.r_cptr, 4'd3);
    chk("cr_count", count_o, 4'd5);
    cycle(1'b0);

    // Reset mid-stream with five entries live.
    do_reset(2);
    cycle(1'b0);
    chk("midrst_empty", empty_o, 1'b1);
    chk("midrst_count", count_o, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
